// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder: opcode/value request in,
// 8-bit immediate field beats out, each side with its own valid/ready pair.
interface imm_encoder_if #(
    parameter int ERR_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_opcode;
    logic [15:0]      i_value;
    logic             o_valid;
    logic             i_ready;
    logic [7:0]       o_immField;
    logic             o_fits;
    logic             o_part;
    logic [ERR_W-1:0] o_errCount;

    modport master (
        output i_valid, i_opcode, i_value, i_ready,
        input  o_ready, o_valid, o_immField, o_fits, o_part, o_errCount
    );

    modport slave (
        input  i_valid, i_opcode, i_value, i_ready,
        output o_ready, o_valid, o_immField, o_fits, o_part, o_errCount
    );
endinterface

// File: rtl/imm_encoder.sv
// Inverse immediate generator: picks the opcode's immediate format, checks that
// the value round-trips, and emits the field through a one-deep output stage.
module imm_encoder #(
    parameter int ERR_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    imm_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               ready_s;
    logic               accept_s;

    logic               do6_s;
    logic               do8_s;
    logic               sh_s;
    logic [15:0]        pre_s;
    logic [3:0]         msb_s;
    logic signed [15:0] top_s;
    logic [7:0]         field_s;
    logic               fits_s;
    logic               split_s;

    logic [7:0]         field_r;
    logic               fits_r;
    logic               part_r;
    logic [7:0]         lo_byte_r;
    logic [ERR_W-1:0]   err_cnt_r;

    // A value is representable when everything above the field's sign bit is sign copy.
    function automatic logic all_same(input logic [15:0] x);
        return (x == 16'h0000) || (x == 16'hFFFF);
    endfunction

    // Format decode, fit check and truncated field for the current request.
    always_comb begin
        do6_s   = ~bus.i_opcode[3] & ~bus.i_opcode[1];
        do8_s   = ~bus.i_opcode[2] & bus.i_opcode[1] & ~bus.i_opcode[0];
        sh_s    = ~bus.i_opcode[3];
        pre_s   = sh_s ? {bus.i_value[15], bus.i_value[15:1]} : bus.i_value;
        msb_s   = 4'd4;
        field_s = {3'b000, pre_s[4:0]};
        if (do8_s) begin
            msb_s   = 4'd7;
            field_s = pre_s[7:0];
        end else if (do6_s) begin
            msb_s   = 4'd5;
            field_s = {2'b00, pre_s[5:0]};
        end else begin
            msb_s   = 4'd4;
            field_s = {3'b000, pre_s[4:0]};
        end
        top_s   = $signed(pre_s) >>> msb_s;
        fits_s  = (~sh_s | ~bus.i_value[0]) & all_same(top_s);
        split_s = (bus.i_opcode == 4'b1010) & ~fits_s;
    end

    // Handshake and next-state logic; the high beat of a split blocks new requests.
    always_comb begin
        state_next_s = state_r;
        ready_s      = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_ONE:  ready_s = bus.i_ready;
            ST_LO:   ready_s = bus.i_ready;
            ST_HI:   ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
        accept_s = bus.i_valid & ready_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = split_s ? ST_HI : ST_ONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ONE, ST_LO: begin
                if (accept_s) begin
                    state_next_s = split_s ? ST_HI : ST_ONE;
                end else if (bus.i_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HI: begin
                if (bus.i_ready) begin
                    state_next_s = ST_LO;
                end else begin
                    state_next_s = ST_HI;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output beat registers, pending low byte and saturating misfit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            field_r   <= 8'h00;
            fits_r    <= 1'b0;
            part_r    <= 1'b0;
            lo_byte_r <= 8'h00;
            err_cnt_r <= {ERR_W{1'b0}};
        end else begin
            if (accept_s) begin
                if (split_s) begin
                    field_r   <= bus.i_value[15:8];
                    fits_r    <= 1'b1;
                    part_r    <= 1'b1;
                    lo_byte_r <= bus.i_value[7:0];
                end else begin
                    field_r <= field_s;
                    fits_r  <= fits_s;
                    part_r  <= 1'b0;
                end
            end else if ((state_r == ST_HI) && bus.i_ready) begin
                field_r <= lo_byte_r;
                fits_r  <= 1'b1;
                part_r  <= 1'b0;
            end
            if (accept_s && !fits_s && !split_s && (err_cnt_r != {ERR_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.o_ready    = ready_s;
    assign bus.o_valid    = (state_r != ST_IDLE);
    assign bus.o_immField = field_r;
    assign bus.o_fits     = fits_r;
    assign bus.o_part     = part_r;
    assign bus.o_errCount = err_cnt_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed scenarios plus random traffic, checked against
// an arithmetic reference model and a queue of expected output beats.
module tb_imm_encoder;

    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct packed {
        logic [7:0] fld;
        logic       fits;
        logic       part;
    } beat_t;

    logic  clk;
    logic  rst;
    int    n_checks;
    int    n_fail;
    int    n_acc;
    int    err_m;
    beat_t q[$];

    imm_encoder_if #(.ERR_W(ERR_W)) bus ();

    imm_encoder #(.ERR_W(ERR_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: target range and field computed with plain integer arithmetic.
    function automatic void ref_encode(input logic [3:0] op, input logic [15:0] val,
                                       output logic [7:0] fld, output bit fit, output bit spl);
        int  v;
        int  p;
        int  w;
        bit  sh;
        v  = int'($signed(val));
        sh = (op[3] == 1'b0);
        if (op[2] == 1'b0 && op[1] == 1'b1 && op[0] == 1'b0) w = 8;
        else if (op[3] == 1'b0 && op[1] == 1'b0) w = 6;
        else w = 5;
        p   = sh ? (v - (v & 1)) / 2 : v;
        fit = (!sh || (v & 1) == 0) && (p >= -(1 << (w - 1))) && (p < (1 << (w - 1)));
        fld = 8'(p & ((1 << w) - 1));
        spl = (op == 4'hA) && !fit;
    endfunction

    task automatic cycle(input logic vld, input logic [3:0] op, input logic [15:0] val, input logic rdy);
        bit         m_ready;
        logic [7:0] f;
        bit         ft;
        bit         sp;
        beat_t      h;
        @(negedge clk);
        bus.i_valid  = vld;
        bus.i_opcode = op;
        bus.i_value  = val;
        bus.i_ready  = rdy;
        #1;
        m_ready = (q.size() == 0) || (q.size() == 1 && rdy);
        check_eq("o_ready", bus.o_ready, m_ready);
        check_eq("o_valid", bus.o_valid, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            check_eq("field", bus.o_immField, h.fld);
            check_eq("fits", bus.o_fits, h.fits);
            check_eq("part", bus.o_part, h.part);
        end
        check_eq("errCount", bus.o_errCount, err_m);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (vld && m_ready) begin
            n_acc++;
            ref_encode(op, val, f, ft, sp);
            if (sp) begin
                q.push_back('{fld: val[15:8], fits: 1'b1, part: 1'b1});
                q.push_back('{fld: val[7:0],  fits: 1'b1, part: 1'b0});
            end else begin
                q.push_back('{fld: f, fits: ft, part: 1'b0});
                if (!ft && err_m < ERR_MAX) err_m++;
            end
        end
    endtask

    // Peek at the outputs just after the edge that follows the last cycle() call.
    task automatic expect_out(input string tag, input logic [7:0] fld, input logic fits,
                              input logic part, input int err);
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, bus.o_valid, 1'b1);
        check_eq({tag, ".field"}, bus.o_immField, fld);
        check_eq({tag, ".fits"}, bus.o_fits, fits);
        check_eq({tag, ".part"}, bus.o_part, part);
        check_eq({tag, ".err"}, bus.o_errCount, err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        err_m = 0;
        check_eq("rst.valid", bus.o_valid, 1'b0);
        check_eq("rst.field", bus.o_immField, 8'h00);
        check_eq("rst.fits", bus.o_fits, 1'b0);
        check_eq("rst.part", bus.o_part, 1'b0);
        check_eq("rst.err", bus.o_errCount, 0);
        check_eq("rst.ready", bus.o_ready, 1'b1);
    endtask

    initial begin
        int         acc0;
        logic [15:0] v;
        n_checks     = 0;
        n_fail       = 0;
        n_acc        = 0;
        err_m        = 0;
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_opcode = 4'h0;
        bus.i_value  = 16'h0000;
        bus.i_ready  = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        cycle(1'b1, 4'h1, 16'hFFC0, 1'b1); expect_out("sh6_fit", 8'h20, 1'b1, 1'b0, 0);
        cycle(1'b1, 4'h1, 16'h0040, 1'b1); expect_out("sh6_mis", 8'h20, 1'b0, 1'b0, 1);
        cycle(1'b1, 4'hA, 16'h007F, 1'b1); expect_out("li_fit", 8'h7F, 1'b1, 1'b0, 1);
        cycle(1'b1, 4'hA, 16'h1234, 1'b1); expect_out("li_hi", 8'h12, 1'b1, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h8, 16'h0000, 1'b0);
            check_eq("hi_blocked", bus.o_ready, 1'b0);
            expect_out("hi_hold", 8'h12, 1'b1, 1'b1, 1);
        end
        cycle(1'b0, 4'h0, 16'h0000, 1'b1); expect_out("li_lo", 8'h34, 1'b1, 1'b0, 1);
        cycle(1'b0, 4'h0, 16'h0000, 1'b1);
        cycle(1'b1, 4'h8, 16'hFFF0, 1'b1); expect_out("f5_fit", 8'h10, 1'b1, 1'b0, 1);
        cycle(1'b1, 4'h8, 16'h0010, 1'b1); expect_out("f5_mis", 8'h10, 1'b0, 1'b0, 2);
        cycle(1'b1, 4'h2, 16'h0011, 1'b1); expect_out("odd", 8'h08, 1'b0, 1'b0, 3);
        cycle(1'b1, 4'h2, 16'h00FE, 1'b1); expect_out("even", 8'h7F, 1'b1, 1'b0, 3);
        cycle(1'b0, 4'h0, 16'h0000, 1'b1);

        // Reset while the high beat is held: the low beat must never appear.
        cycle(1'b1, 4'hA, 16'hBEEF, 1'b1);
        cycle(1'b0, 4'h0, 16'h0000, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 4'h0, 16'h0000, 1'b1);

        acc0 = n_acc;
        for (int i = 0; i < 260; i++) cycle(1'b1, 4'h8, 16'h0100, 1'b1);
        cycle(1'b0, 4'h0, 16'h0000, 1'b1);
        check_eq("sat.err", bus.o_errCount, ERR_MAX);
        check_eq("sat.accepts", n_acc - acc0, 260);

        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) v = 16'($urandom);
            else v = 16'($signed(8'($urandom)));
            cycle($urandom_range(0, 3) != 0, 4'($urandom), v, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        cycle(1'b0, 4'h0, 16'h0000, 1'b1);
        cycle(1'b0, 4'h0, 16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
